// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    SHADOW = 2'd2,
    HALT   = 2'd3
  } pc_state_e;

  localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/pc_sequencer_redirect_select.sv
// Picks the EX-stage redirect source (jalr over branch) and checks the
// chosen target for alignment and for bits beyond the fetch address width.
module redirect_select #(
  parameter int PC_W = 9
) (
  input  logic            br_taken_i,
  input  logic [31:0]     br_target_i,
  input  logic            jalr_taken_i,
  input  logic [31:0]     jalr_target_i,
  output logic            redirect_o,
  output logic [PC_W-1:0] target_pc_o,
  output logic            misalign_o,
  output logic            range_err_o
);

  logic [31:0] target;

  // jalr clears bit 0 of rs1+imm before use
  assign target      = jalr_taken_i ? {jalr_target_i[31:1], 1'b0} : br_target_i;
  assign redirect_o  = br_taken_i | jalr_taken_i;
  assign target_pc_o = target[PC_W-1:0];
  assign misalign_o  = |target[1:0];
  assign range_err_o = |target[31:PC_W];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: boot, sequential fetch, stall hold, EX redirects with a
// one-cycle shadow, halt, sticky target errors and a saturating redirect count.
//   state  | meaning
//   BOOT   | first cycle after reset, fetch slot empty
//   RUN    | normal fetch; halt, redirect, stall or PC+4
//   SHADOW | cycle after a redirect, all requests masked, PC+4
//   HALT   | PC frozen until reset
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             jalr_taken,
  input  logic [31:0]      jalr_target,
  input  logic             halt_req,
  output logic [PC_W-1:0]  pc,
  output logic             pc_valid,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             halted,
  output logic             err_misalign,
  output logic             err_range,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [PC_W-1:0] STEP = PC_W'(INSN_BYTES);

  pc_state_e        state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mis_q, mis_d;
  logic             rng_q, rng_d;

  logic             redirect;
  logic [PC_W-1:0]  target_pc;
  logic             tgt_misalign;
  logic             tgt_range;

  redirect_select #(.PC_W(PC_W)) u_redirect_select (
    .br_taken_i    (br_taken),
    .br_target_i   (br_target),
    .jalr_taken_i  (jalr_taken),
    .jalr_target_i (jalr_target),
    .redirect_o    (redirect),
    .target_pc_o   (target_pc),
    .misalign_o    (tgt_misalign),
    .range_err_o   (tgt_range)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      rng_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      rng_q   <= rng_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    rng_d   = rng_q;
    case (state_q)
      BOOT:   state_d = RUN;
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (redirect) begin
          if (tgt_misalign) begin
            mis_d   = 1'b1;
            state_d = HALT;
          end else begin
            // out-of-range targets still redirect on the truncated address
            pc_d    = target_pc;
            state_d = SHADOW;
            if (tgt_range) rng_d = 1'b1;
            if (~&cnt_q) cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (!stall) begin
          pc_d = pc_q + STEP;
        end
      end
      SHADOW: begin
        pc_d    = pc_q + STEP;
        state_d = RUN;
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_valid     = (state_q == RUN) || (state_q == SHADOW);
    halted       = (state_q == HALT);
    flush_if_id  = (state_q == RUN) && redirect && !halt_req;
    flush_id_ex  = flush_if_id;
    pc           = pc_q;
    err_misalign = mis_q;
    err_range    = rng_q;
    redirect_cnt = cnt_q;
  end

endmodule
